// File: rtl/led_fade_pkg.sv
// Shared mode encodings and small helpers for the LED fade engine.
package led_fade_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  function automatic mode_e mode_advance(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  // Callers truncate the result to their own channel count.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pwm_level_channel.sv
// One PWM output: level is captured at period start so duty never changes mid-period.
module pwm_level_channel #(
  parameter int LEVELWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEVELWIDTH-1:0] cnt,
  input  logic                  wrap,
  input  logic [LEVELWIDTH-1:0] level,
  output logic                  led_n
);

  logic [LEVELWIDTH-1:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       shadow <= '0;
    else if (wrap) shadow <= level;
  end

  assign led_n = ~(cnt < shadow);

endmodule

// File: rtl/led_fade_sequencer.sv
// Multi-channel LED fade engine: per-channel levels ramp toward mode targets,
// driven by clock-enable prescalers and a shared PWM counter.
module led_fade_sequencer
  import led_fade_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int PWM_DEGREE = 100,
  parameter int PWM_DIV    = 240,
  parameter int STEP_DIV   = 1200000,
  parameter int LEVEL_MAX  = 50,
  parameter int LEVELWIDTH = 10,
  parameter int RESET_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_next,
  input  logic                hold,
  output logic [CHANNELS-1:0] led_n,
  output logic [1:0]          mode_o,
  output logic [CHANNELS-1:0] gray_o,
  output logic                settled_o
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PDIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0]     STEP_ONE  = STEP_W'(1);
  localparam logic [PDIV_W-1:0]     PDIV_LAST = PDIV_W'(PWM_DIV - 1);
  localparam logic [PDIV_W-1:0]     PDIV_ONE  = PDIV_W'(1);
  localparam logic [LEVELWIDTH-1:0] PWM_LAST  = LEVELWIDTH'(PWM_DEGREE - 1);
  localparam logic [LEVELWIDTH-1:0] LVL_ONE   = LEVELWIDTH'(1);
  localparam logic [LEVELWIDTH-1:0] LMAX      = LEVELWIDTH'(LEVEL_MAX);
  localparam logic [CHANNELS-1:0]   B_ONE     = CHANNELS'(1);
  localparam mode_e                 RST_MODE  = mode_e'(RESET_MODE[1:0]);

  logic [STEP_W-1:0]                    step_cnt;
  logic [PDIV_W-1:0]                    pdiv_cnt;
  logic [LEVELWIDTH-1:0]                pwm_cnt;
  logic                                 step_tick, pwm_tick, pwm_wrap;
  mode_e                                mode;
  logic [CHANNELS-1:0]                  b;
  logic                                 dir;
  logic [CHANNELS-1:0][LEVELWIDTH-1:0]  level, target;

  assign step_tick = (step_cnt == STEP_LAST);
  assign pwm_tick  = (pdiv_cnt == PDIV_LAST);
  assign pwm_wrap  = pwm_tick && (pwm_cnt == PWM_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      pdiv_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      step_cnt <= step_tick ? '0 : step_cnt + STEP_ONE;
      pdiv_cnt <= pwm_tick  ? '0 : pdiv_cnt + PDIV_ONE;
      if (pwm_tick) pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + LVL_ONE;
    end
  end

  assign gray_o = CHANNELS'(bin2gray(32'(b)));
  assign mode_o = mode;

  always_comb begin
    target = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode)
        MODE_WALK:    target[i] = gray_o[i] ? LMAX : '0;
        MODE_BREATHE: target[i] = dir ? LMAX : '0;
        MODE_STATIC:  target[i] = LMAX;
        default:      target[i] = '0;
      endcase
    end
  end

  assign settled_o = (level == target);

  // A settled step is spent on advancing the pattern, never on moving levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode  <= RST_MODE;
      b     <= '0;
      dir   <= 1'b1;
      level <= '0;
    end else begin
      if (mode_next) mode <= mode_advance(mode);
      if (step_tick && !hold) begin
        if (!settled_o) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (level[i] < target[i])      level[i] <= level[i] + LVL_ONE;
            else if (level[i] > target[i]) level[i] <= level[i] - LVL_ONE;
          end
        end else if (mode == MODE_WALK) begin
          b <= b + B_ONE;
        end else if (mode == MODE_BREATHE) begin
          dir <= ~dir;
        end
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_level_channel #(.LEVELWIDTH(LEVELWIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .cnt   (pwm_cnt),
      .wrap  (pwm_wrap),
      .level (level[i]),
      .led_n (led_n[i])
    );
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer: edge-counting reference model plus directed literal checks.
module tb_led_fade_sequencer;

  localparam int CH = 3, PDEG = 4, PDIV = 2, SDIV = 8, LM = 2;

  logic clk = 0, rst = 1, mode_next = 0, hold = 0, zero = 0;
  logic [CH-1:0] led_n, gray_o, led2_n, gray2;
  logic [1:0]    mode_o, mode2;
  logic          settled_o, settled2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  led_fade_sequencer #(.CHANNELS(CH), .PWM_DEGREE(PDEG), .PWM_DIV(PDIV), .STEP_DIV(SDIV),
                       .LEVEL_MAX(LM), .LEVELWIDTH(10), .RESET_MODE(1)) dut (
    .clk(clk), .rst(rst), .mode_next(mode_next), .hold(hold),
    .led_n(led_n), .mode_o(mode_o), .gray_o(gray_o), .settled_o(settled_o));

  // Second instance: STATIC from reset with LEVEL_MAX equal to PWM_DEGREE.
  led_fade_sequencer #(.CHANNELS(CH), .PWM_DEGREE(PDEG), .PWM_DIV(PDIV), .STEP_DIV(SDIV),
                       .LEVEL_MAX(PDEG), .LEVELWIDTH(10), .RESET_MODE(3)) dut2 (
    .clk(clk), .rst(rst), .mode_next(zero), .hold(zero),
    .led_n(led2_n), .mode_o(mode2), .gray_o(gray2), .settled_o(settled2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts clock edges since reset release.
  int k = 0, m_mode = 1, m_b = 0;
  bit m_dir = 1;
  int m_lvl[CH], m_sh[CH];

  function automatic int m_gray();
    return m_b ^ (m_b >> 1);
  endfunction

  function automatic int tgt(int i);
    case (m_mode)
      0:       return 0;
      1:       return ((m_gray() >> i) & 1) != 0 ? LM : 0;
      2:       return m_dir ? LM : 0;
      default: return LM;
    endcase
  endfunction

  function automatic bit m_settled();
    for (int i = 0; i < CH; i++) if (m_lvl[i] != tgt(i)) return 0;
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int old[CH];
    bit st;
    if (rst) begin
      k = 0; m_mode = 1; m_b = 0; m_dir = 1;
      for (int i = 0; i < CH; i++) begin m_lvl[i] = 0; m_sh[i] = 0; end
    end else begin
      k++;
      st = m_settled();
      for (int i = 0; i < CH; i++) old[i] = m_lvl[i];
      if (k % SDIV == 0 && !hold) begin
        if (!st) begin
          for (int i = 0; i < CH; i++) begin
            if (m_lvl[i] < tgt(i))      m_lvl[i]++;
            else if (m_lvl[i] > tgt(i)) m_lvl[i]--;
          end
        end else if (m_mode == 1) m_b = (m_b + 1) % (1 << CH);
        else if (m_mode == 2) m_dir = !m_dir;
      end
      if (k % PDIV == 0 && (k / PDIV) % PDEG == 0)
        for (int i = 0; i < CH; i++) m_sh[i] = old[i];
      if (mode_next) m_mode = (m_mode + 1) % 4;
    end
  end

  always @(negedge clk) if (!rst) begin : cmp
    logic [CH-1:0] e_led;
    int pc;
    pc = (k / PDIV) % PDEG;
    for (int i = 0; i < CH; i++) e_led[i] = !(pc < m_sh[i]);
    chk("led_n", 32'(led_n), 32'(e_led));
    chk("mode_o", 32'(mode_o), m_mode);
    chk("gray_o", 32'(gray_o), m_gray());
    chk("settled_o", 32'(settled_o), 32'(m_settled()));
  end

  task automatic pulse_mode();
    @(negedge clk) mode_next = 1;
    @(negedge clk) mode_next = 0;
  endtask

  logic [2:0] gq[$];
  logic [2:0] exp_seq[9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] g0;
  int lows, lows2;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_led_n", 32'(led_n), 32'd7);
    chk("rst_mode", 32'(mode_o), 32'd1);
    chk("rst_gray", 32'(gray_o), 32'd0);
    chk("rst_settled", 32'(settled_o), 32'd1);
    chk("rst2_led_n", 32'(led2_n), 32'd7);
    chk("rst2_settled", 32'(settled2), 32'd0);
    #1 rst = 0;

    // Full WALK run from reset.
    gq.push_back(gray_o);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (gray_o != gq[gq.size()-1]) gq.push_back(gray_o);
      if (c == 8)  chk("first_tick_gray", 32'(gray_o), 32'd1);
      if (c == 16) chk("ramping_unsettled", 32'(settled_o), 32'd0);
      if (c == 24) chk("level0_at_max", 32'(settled_o), 32'd1);
      if (c == 32) chk("second_gray", 32'(gray_o), 32'd3);
    end
    chk("walk_len", 32'(gq.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < gq.size(); i++) chk("walk_seq", 32'(gq[i]), 32'(exp_seq[i]));

    // Into BREATHE while level0 is mid-ramp.
    repeat (33) @(negedge clk);
    pulse_mode();
    chk("breathe_mode", 32'(mode_o), 32'd2);
    repeat (120) @(negedge clk);

    // STATIC: duty 2 of 4 on main, constant on on second instance.
    pulse_mode();
    repeat (64) @(negedge clk);
    lows = 0; lows2 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!led_n[0]) lows++;
      if (led2_n == 3'b000) lows2++;
    end
    chk("static_duty", lows, 32'd4);
    chk("full_level_const", lows2, 32'd8);

    // Hold in WALK freezes the pattern.
    pulse_mode();
    repeat (40) @(negedge clk);
    pulse_mode();
    hold = 1;
    g0 = gray_o;
    repeat (40) @(negedge clk);
    chk("hold_gray", 32'(gray_o), 32'(g0));
    hold = 0;
    repeat (30) @(negedge clk);

    // Randomised mode pulses and hold.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mode_next = ($urandom_range(39) == 0);
      hold      = ($urandom_range(3) == 0);
    end
    @(negedge clk);
    mode_next = 0; hold = 0;

    // Asynchronous reset mid-breathe.
    for (int n = 0; n < 4 && m_mode != 2; n++) pulse_mode();
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("arst_led_n", 32'(led_n), 32'd7);
    chk("arst_mode", 32'(mode_o), 32'd1);
    chk("arst_gray", 32'(gray_o), 32'd0);
    chk("arst_settled", 32'(settled_o), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_sequencer.md
# led_fade_sequencer

Parametrised multi-channel LED fade engine: N PWM channels, each with a brightness level that ramps one step per fade tick toward a mode-dependent target. Four modes (off, Gray-code colour walk, synchronous breathing, static full) are cycled by a one-cycle command pulse. It runs entirely on the board clock using internal tick prescalers, with no derived clocks. It sits between the button filters and the active-low RGB pins.

## Interface
- CHANNELS, 3, number of LED channels (≥1)
- PWM_DEGREE, 100, PWM period in PWM ticks
- PWM_DIV, 240, clk cycles per PWM tick (≥1)
- STEP_DIV, 1200000, clk cycles per fade step (≥1)
- LEVEL_MAX, 50, maximum level (≤PWM_DEGREE)
- LEVELWIDTH, 10, level/PWM counter width (must hold PWM_DEGREE)
- RESET_MODE, 1, mode after reset
- clk  in  1  board clock
- rst  in  1  reset, asynchronous, active-high
- mode_next  in  1  one-cycle pulse; advance mode
- hold  in  1  level 1 freezes fade steps and Gray advance; PWM keeps running
- led_n  out  CHANNELS  PWM outputs, active-low (0 = lit)
- mode_o  out  2  current mode
- gray_o  out  CHANNELS  current Gray pattern
- settled_o  out  1  all levels equal their targets

## Operation
- Modes: 0 OFF (target 0), 1 WALK (target_i = gray[i] ? LEVEL_MAX : 0), 2 BREATHE (all targets = dir ? LEVEL_MAX : 0), 3 STATIC (target LEVEL_MAX).
- mode_next: mode ← mode+1 mod 4 on the next edge. Levels are not reset; they ramp from their current value.
- Fade step (step_tick && !hold), evaluated against pre-edge mode, levels, gray and dir:
  - not settled: each level ≠ target moves ±1 toward its target; others hold.
  - settled, WALK: Gray binary counter b ← b+1, wrapping at 2^CHANNELS; gray = b ^ (b>>1). No level movement on this tick.
  - settled, BREATHE: dir ← ~dir. No movement on this tick.
  - settled, OFF/STATIC: nothing.
- PWM: one shared counter 0..PWM_DEGREE-1 advances per pwm_tick and wraps to 0. Each channel latches its level into a shadow register when the counter wraps (period start). led_n[i] = ~(cnt < shadow[i]). Level 0 gives led_n = 1 for the whole period. LEVEL_MAX = PWM_DEGREE gives constant 0.
- settled_o is combinational from levels and targets.

## Timing
- Reset values:
  - mode = RESET_MODE
  - levels and shadows = 0
  - b = 0, gray_o = 0
  - dir = 1
  - prescalers and PWM counter = 0
  - led_n = all 1
  - settled_o reflects RESET_MODE with all levels 0 (1 for OFF and for WALK with gray 0).
- step_tick is high one cycle every STEP_DIV clocks. The first tick is at cycle STEP_DIV after rst falls.
- pwm_tick is high one cycle every PWM_DIV clocks. The first tick is at cycle PWM_DIV after rst falls.
- Level change to visible duty: takes effect at the next PWM period start, at most PWM_DEGREE·PWM_DIV clocks later.
- mode_next coinciding with step_tick: the step uses the old mode; the new mode applies from the next step.
- hold asserted on a step_tick: that tick is lost (not deferred). Prescalers keep running.
- rst mid-fade: all state returns to reset values immediately. No partial PWM period is emitted.

## Structure
- Package led_fade_pkg holds:
  - mode encodings MODE_OFF/WALK/BREATHE/STATIC (2-bit)
  - the mode-advance function
  - the binary-to-Gray function
- Sub-module pwm_level_channel is instantiated CHANNELS times. Inputs: clk, rst, the shared counter, a wrap strobe, and the level. Output: led_n bit. It contains the shadow register and the compare.
- Prescalers, mode register, Gray counter, dir and level registers live in the top.

## Test plan
Use CHANNELS=3, PWM_DEGREE=4, PWM_DIV=2, STEP_DIV=8, LEVEL_MAX=2, RESET_MODE=1 unless noted.

1. Reset → led_n=3'b111, mode_o=1, gray_o=0, settled_o=1. The first step tick advances gray_o to 3'b001. Two further ticks bring level0 to 2. The next tick gives gray_o=3'b011.
2. Full WALK run: gray_o sequence 000,001,011,010,110,111,101,100,000 (wraps). Ramp ticks are inserted whenever the pattern is not settled.
3. mode_next pulse while level0=1 and ramping up, into BREATHE → mode_o=2. Level0 continues 1→2 with no jump. Once all levels reach 2, dir flips and all ramp to 0.
4. STATIC with level 2 → led_n[i] low for exactly 2 of every 4 PWM ticks (4 of 8 clocks). Setting LEVEL_MAX=4 → constant 0.
5. hold=1 across 3 step ticks → levels and gray frozen while PWM keeps toggling. hold=0 → stepping resumes at the next tick.
6. Assert rst mid-breathe with level=1 → all outputs return to reset values within the same cycle (asynchronous).
